// File: rtl/pfd_loop_filter.sv
// Digital charge pump and PI loop filter for the all-digital PLL.
// Converts PFD up/down pulse widths into a saturated DCO control word.
module pfd_loop_filter #(
    parameter int CTRL_W    = 12,
    parameter int CTRL_INIT = 2048,
    parameter int ERR_W     = 8,
    parameter int INT_W     = 16,
    parameter int KP_SHIFT  = 2,
    parameter int KI_SHIFT  = 4,
    parameter int LOCK_TOL  = 1,
    parameter int LOCK_CNT  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    up,
    input  logic                    down,
    output logic [CTRL_W-1:0]       ctrl_word,
    output logic                    ctrl_valid,
    output logic signed [ERR_W:0]   err_last,
    output logic                    lock
);

    localparam int SUM_W = INT_W + ERR_W + KP_SHIFT + 2;
    localparam int LC_W  = $clog2(LOCK_CNT + 1);

    localparam logic [ERR_W-1:0]        CNT_MAX = '1;
    localparam logic signed [INT_W:0]   INT_MAX = (INT_W+1)'((1 <<< (INT_W-1)) - 1);
    localparam logic signed [INT_W:0]   INT_MIN = -INT_MAX;
    localparam logic signed [SUM_W-1:0] INIT_S  = SUM_W'(CTRL_INIT);
    localparam logic signed [SUM_W-1:0] CMAX_S  = SUM_W'((1 <<< CTRL_W) - 1);
    localparam logic signed [ERR_W:0]   TOL_S   = (ERR_W+1)'(LOCK_TOL);
    localparam logic [LC_W-1:0]         LC_MAX  = LC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        MEAS_UP,
        MEAS_DN,
        UPDATE
    } state_t;

    state_t                   state;
    logic [ERR_W-1:0]         count;
    logic signed [ERR_W:0]    err;
    logic signed [INT_W-1:0]  integ;
    logic [LC_W-1:0]          lock_cnt;

    logic signed [INT_W:0]    isum;
    logic signed [INT_W-1:0]  integ_n;
    logic signed [SUM_W-1:0]  psum;
    logic [CTRL_W-1:0]        ctrl_n;
    logic                     in_tol;
    logic [LC_W-1:0]          lock_cnt_n;
    logic                     start_up;
    logic                     start_dn;

    // Filter arithmetic runs off the latched error; only UPDATE commits it.
    always_comb begin
        isum = (INT_W+1)'(integ) + (INT_W+1)'(err);
        if (isum > INT_MAX)
            integ_n = INT_MAX[INT_W-1:0];
        else if (isum < INT_MIN)
            integ_n = INT_MIN[INT_W-1:0];
        else
            integ_n = isum[INT_W-1:0];

        psum = INIT_S
             + (SUM_W'(err) <<< KP_SHIFT)
             + SUM_W'(integ_n >>> KI_SHIFT);
        if (psum[SUM_W-1])
            ctrl_n = '0;
        else if (psum > CMAX_S)
            ctrl_n = '1;
        else
            ctrl_n = psum[CTRL_W-1:0];

        in_tol = (err <= TOL_S) && (err >= -TOL_S);
        if (!in_tol)
            lock_cnt_n = '0;
        else if (lock_cnt == LC_MAX)
            lock_cnt_n = LC_MAX;
        else
            lock_cnt_n = lock_cnt + 1'b1;

        start_up = enable && up && !down;
        start_dn = enable && down && !up;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            err        <= '0;
            integ      <= '0;
            lock_cnt   <= '0;
            ctrl_word  <= CTRL_W'(CTRL_INIT);
            ctrl_valid <= 1'b0;
            err_last   <= '0;
            lock       <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            unique case (state)
                IDLE, UPDATE: begin
                    if (state == UPDATE) begin
                        integ      <= integ_n;
                        ctrl_word  <= ctrl_n;
                        err_last   <= err;
                        ctrl_valid <= 1'b1;
                        lock_cnt   <= lock_cnt_n;
                        lock       <= (lock_cnt_n == LC_MAX);
                    end
                    unique case (1'b1)
                        start_up: begin
                            state <= MEAS_UP;
                            count <= ERR_W'(1);
                        end
                        start_dn: begin
                            state <= MEAS_DN;
                            count <= ERR_W'(1);
                        end
                        default: state <= IDLE;
                    endcase
                end
                MEAS_UP: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (up && !down) begin
                        if (count != CNT_MAX)
                            count <= count + 1'b1;
                    end else begin
                        err   <= $signed({1'b0, count});
                        state <= UPDATE;
                    end
                end
                MEAS_DN: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (down && !up) begin
                        if (count != CNT_MAX)
                            count <= count + 1'b1;
                    end else begin
                        err   <= -$signed({1'b0, count});
                        state <= UPDATE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Bench for pfd_loop_filter: pulse-level reference model, directed
// literal checks and randomized PFD pulse trains.
module tb_pfd_loop_filter;

    localparam int CTRL_INIT = 2048;
    localparam int CTRL_MAX  = 4095;
    localparam int CNT_MAX   = 255;
    localparam int INT_LIM   = 32767;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b1;
    logic              up = 1'b0;
    logic              down = 1'b0;
    logic [11:0]       ctrl_word;
    logic              ctrl_valid;
    logic signed [8:0] err_last;
    logic              lock;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    pfd_loop_filter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .up         (up),
        .down       (down),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .err_last   (err_last),
        .lock       (lock)
    );

    always #5 clk = ~clk;

    // Reference model: pulse direction/length and a pending filter update.
    int mdir = 0;
    int mlen = 0;
    bit pend = 0;
    int perr = 0;
    int minteg = 0;
    int mctrl = CTRL_INIT;
    int merr = 0;
    int mlockn = 0;
    bit mlock = 0;
    bit mvalid = 0;

    function automatic int floor_div16(int s);
        if (s >= 0) return s / 16;
        return -((-s + 15) / 16);
    endfunction

    task automatic m_update(int e);
        int s;
        int c;
        s = minteg + e;
        if (s > INT_LIM) s = INT_LIM;
        if (s < -INT_LIM) s = -INT_LIM;
        minteg = s;
        c = CTRL_INIT + e * 4 + floor_div16(minteg);
        if (c < 0) c = 0;
        if (c > CTRL_MAX) c = CTRL_MAX;
        mctrl = c;
        merr = e;
        if (e >= -1 && e <= 1) begin
            if (mlockn < 8) mlockn = mlockn + 1;
            mlock = (mlockn == 8);
        end else begin
            mlockn = 0;
            mlock = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdir = 0; mlen = 0; pend = 0; perr = 0; minteg = 0;
            mctrl = CTRL_INIT; merr = 0; mlockn = 0; mlock = 0; mvalid = 0;
        end else begin
            mvalid = 0;
            if (pend) begin
                m_update(perr);
                mvalid = 1;
                pend = 0;
            end
            if (mdir == 0) begin
                if (enable && (up != down)) begin
                    mdir = up ? 1 : -1;
                    mlen = 1;
                end
            end else if (!enable) begin
                mdir = 0;
            end else if ((mdir > 0 && up && !down) || (mdir < 0 && down && !up)) begin
                if (mlen < CNT_MAX) mlen = mlen + 1;
            end else begin
                perr = mdir * mlen;
                pend = 1;
                mdir = 0;
            end
        end
    end

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_ctrl_word", int'(ctrl_word), mctrl);
            check("cmp_ctrl_valid", int'(ctrl_valid), int'(mvalid));
            check("cmp_err_last", int'(err_last), merr);
            check("cmp_lock", int'(lock), int'(mlock));
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(bit u, bit d, int n);
        up = u;
        down = d;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        up = 1'b0;
        down = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(string name, int maxc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ctrl_valid && k < maxc);
        check(name, int'(ctrl_valid), 1);
    endtask

    task automatic expect_quiet(string name, int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (ctrl_valid) cnt++;
        end
        check(name, cnt, 0);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("rst_ctrl_word", int'(ctrl_word), 2048);
        check("rst_ctrl_valid", int'(ctrl_valid), 0);
        check("rst_err_last", int'(err_last), 0);
        check("rst_lock", int'(lock), 0);

        // 5-cycle up pulse
        drive(1, 0, 5);
        up = 0;
        wait_valid("t1_valid", 20);
        check("t1_err", int'(err_last), 5);
        check("t1_ctrl", int'(ctrl_word), 2068);
        check("t1_integ_model", minteg, 5);
        @(negedge clk);
        check("t1_valid_one_cycle", int'(ctrl_valid), 0);
        sync();

        // 3-cycle down pulse
        do_reset();
        drive(0, 1, 3);
        down = 0;
        wait_valid("t2_valid", 20);
        check("t2_err", int'(err_last), -3);
        check("t2_ctrl", int'(ctrl_word), 2035);
        check("t2_integ_model", minteg, -3);
        sync();

        // counter saturation
        do_reset();
        drive(1, 0, 300);
        up = 0;
        wait_valid("t3_valid", 20);
        check("t3_err", int'(err_last), 255);
        check("t3_ctrl", int'(ctrl_word), 3083);
        check("t3_integ_model", minteg, 255);
        sync();

        // control word clamp and integrator saturation
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(1, 0, 255);
            drive(0, 0, 2);
            if (i == 79) check("t4_clamp80", int'(ctrl_word), 4095);
        end
        check("t4_clamp200", int'(ctrl_word), 4095);
        check("t4_integ_model", minteg, 32767);

        // lock acquisition and loss
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1);
            up = 0;
            wait_valid("t5_valid", 10);
            check("t5_lock_rise", int'(lock), int'(i == 7));
            sync();
        end
        drive(0, 1, 3);
        down = 0;
        wait_valid("t5_dn_valid", 10);
        check("t5_lock_fall", int'(lock), 0);
        sync();
        drive(1, 1, 4);
        up = 0;
        down = 0;
        expect_quiet("t5_both_high", 8);
        sync();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1);
            drive(0, 0, 3);
        end
        check("t5_relock", int'(lock), 1);

        // async reset mid-pulse
        drive(1, 0, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", int'(ctrl_word), 2048);
        check("t6_rst_lock", int'(lock), 0);
        check("t6_rst_valid", int'(ctrl_valid), 0);
        up = 0;
        sync();
        rst_n = 1'b1;
        sync();

        // enable drop aborts a measurement
        drive(1, 0, 4);
        enable = 0;
        expect_quiet("t6_abort_hold", 6);
        up = 0;
        enable = 1;
        expect_quiet("t6_abort_after", 5);
        check("t6_abort_ctrl", int'(ctrl_word), 2048);
        sync();

        // randomized pulse trains
        for (int i = 0; i < 300; i++) begin
            int n;
            enable = ($urandom_range(0, 9) != 0);
            up = 1'($urandom_range(0, 1));
            down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                sync();
                rst_n = 1'b1;
            end
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300)
                                            : $urandom_range(1, 6);
            repeat (n) @(posedge clk);
            #2;
        end
        up = 0;
        down = 0;
        enable = 1;
        repeat (5) sync();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pfd_loop_filter.md
Name: pfd_loop_filter

Overview:
- Digital charge-pump and PI loop filter that consumes the up/down pulses produced by the phase frequency detector.
- Measures each pulse width in clk cycles as a signed phase error and accumulates it in a saturating integrator.
- Outputs a saturated DCO control word, a one-cycle update strobe and a lock indicator.
- Sits between the PFD and the DCO/feedback divider in the all-digital PLL.

Parameters:
- CTRL_W, 12: control word width.
- CTRL_INIT, 2048: control word value at reset (mid-scale).
- ERR_W, 8: pulse-width counter width; the counter saturates at 2^ERR_W-1.
- INT_W, 16: signed integrator width.
- KP_SHIFT, 2: proportional gain = 2^KP_SHIFT.
- KI_SHIFT, 4: integral gain = 2^-KI_SHIFT (arithmetic right shift).
- LOCK_TOL, 1: maximum |err| that counts as an in-lock update.
- LOCK_CNT, 8: number of consecutive in-lock updates required to assert lock.

Ports:
- clk  in  1  system clock; same domain as the PFD outputs.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  loop enable; when low, the filter is frozen.
- up  in  1  PFD up pulse (reference leads).
- down  in  1  PFD down pulse (feedback leads).
- ctrl_word  out  CTRL_W  DCO control word, unsigned.
- ctrl_valid  out  1  one-cycle strobe on every ctrl_word update.
- err_last  out  ERR_W+1  signed error of the most recent update.
- lock  out  1  loop locked.

Behaviour:
- Reset is asynchronous, on rst_n low, at any time including mid-measurement. Reset values:
  - state IDLE, count 0, integ 0
  - ctrl_word = CTRL_INIT, ctrl_valid = 0, err_last = 0, lock = 0, lock counter 0
- FSM states: IDLE, MEAS_UP, MEAS_DN, UPDATE. All inputs are sampled on rising clk.
- IDLE:
  - up & !down -> MEAS_UP, count = 1.
  - down & !up -> MEAS_DN, count = 1.
  - Both high or both low -> stay in IDLE. No measurement is taken.
- MEAS_UP:
  - While up=1 and down=0: count += 1, saturating at 2^ERR_W-1.
  - First edge with up=0, or with down=1 (opposite pulse): latch err = +count, go to UPDATE.
- MEAS_DN: mirror of MEAS_UP with the roles of up and down swapped; err = -count.
- UPDATE (exactly one cycle). The registers below load at the end of this cycle:
  - integ_n = sat_INT_W(integ + err). Saturation limits are ±(2^(INT_W-1)-1); the integrator never wraps.
  - ctrl_n = clamp(CTRL_INIT + (err << KP_SHIFT) + (integ_n >>> KI_SHIFT), 0, 2^CTRL_W-1).
  - The sum is computed at ≥ INT_W+2 bits, signed.
  - ctrl_word <= ctrl_n, err_last <= err, ctrl_valid <= 1 for exactly one cycle.
  - Next state follows the IDLE rules on the current up/down, so a pulse starting during UPDATE is not lost.
- Latency: let E be the first edge at which the end condition is sampled. ctrl_word, ctrl_valid and lock change at edge E+1. ctrl_valid returns to 0 at E+2 unless another update occurs.
- Lock, evaluated at each update:
  - |err| <= LOCK_TOL: the lock counter increments, saturating at LOCK_CNT. lock asserts when the counter reaches LOCK_CNT.
  - Otherwise: the counter clears and lock deasserts, in the same cycle as ctrl_valid.
- enable=0:
  - FSM is forced to IDLE and any in-progress measurement is discarded.
  - integ, ctrl_word, err_last and lock hold their values. No ctrl_valid is generated.
  - An UPDATE already in progress completes.
- ctrl_word is the only externally visible state the DCO uses. It changes only on ctrl_valid or reset.

Test Plan (default parameters, enable=1 unless stated):
1. After reset, up high for 5 cycles -> at E+1: err_last = +5, integ = 5, ctrl_word = 2048+20+0 = 2068, ctrl_valid high for exactly 1 cycle.
2. After reset, down high for 3 cycles -> err_last = -3, integ = -3, ctrl_word = 2048-12+(-1) = 2035.
3. After reset, up held for 300 cycles -> count saturates; err_last = +255, integ = 255, ctrl_word = 2048+1020+15 = 3083.
4. 80 consecutive 255-cycle up pulses -> ctrl_word clamps at 4095 without wrap. Continue to 200 pulses -> integ holds at 32767 and ctrl_word stays 4095.
5. Lock sequence:
   - After reset, eight 1-cycle up pulses -> lock rises with the 8th ctrl_valid, not the 7th.
   - Then one 3-cycle down pulse -> lock falls in the same cycle as that ctrl_valid.
   - up and down high together in IDLE -> no ctrl_valid.
6. Abort and reset cases:
   - up high for 4 cycles, then enable=0 -> no ctrl_valid and ctrl_word unchanged.
   - rst_n pulsed low mid-pulse -> ctrl_word = 2048, lock = 0, ctrl_valid = 0 immediately, before the next clk edge.
